// File: rtl/pwm_mode_gen.sv
// Key-selected multi-channel PWM generator with synchronised, debounced mode keys.
// Mode changes are deferred to the period wrap so every emitted pulse is full length.
module pwm_mode_gen #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PERIOD_A    = 500,
  parameter int unsigned LOW_A       = 200,
  parameter int unsigned PERIOD_B    = 625,
  parameter int unsigned LOW_B       = 400,
  parameter int unsigned NCH         = 2,
  parameter int unsigned PHASE_STEP  = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYC      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key0,
  input  logic           key1,
  output logic           led0,
  output logic           led1,
  output logic [NCH-1:0] pwm,
  output logic           tick
);

  localparam int unsigned PH_W = CNT_W + 1;
  localparam int unsigned DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  localparam logic [CNT_W-1:0] PER_A   = CNT_W'(PERIOD_A);
  localparam logic [CNT_W-1:0] PER_B   = CNT_W'(PERIOD_B);
  localparam logic [CNT_W-1:0] LOW_A_C = CNT_W'(LOW_A);
  localparam logic [CNT_W-1:0] LOW_B_C = CNT_W'(LOW_B);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2
  } state_t;

  state_t                      state, state_nxt;
  state_t                      pending, pending_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [CNT_W-1:0]            per_c, low_c;
  logic                        wrap_c;
  logic [NCH-1:0]              pwm_nxt;
  logic [1:0]                  key_raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  k_sync;
  logic [1:0]                  k_db;
  logic [1:0][DB_W-1:0]        db_cnt;

  // Index 1 carries key0, index 0 carries key1, matching the {k0,k1} request code.
  assign key_raw = {key0, key1};
  assign k_sync  = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

  // Synchroniser chain and stability counter per key.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      k_db   <= '0;
      db_cnt <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
        if (k_sync[k] == k_db[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          k_db[k]   <= k_sync[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Latest debounced request wins; 00 keeps whatever was asked for last.
  always_comb begin
    pending_nxt = pending;
    case (k_db)
      2'b01:   pending_nxt = RUN_A;
      2'b10:   pending_nxt = RUN_B;
      2'b11:   pending_nxt = IDLE;
      default: pending_nxt = pending;
    endcase
  end

  always_comb begin
    per_c = PER_A;
    low_c = LOW_A_C;
    if (state == RUN_B) begin
      per_c = PER_B;
      low_c = LOW_B_C;
    end
  end

  // Period counter; the pending mode is only adopted on wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wrap_c    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pending != IDLE) state_nxt = pending;
      end
      RUN_A, RUN_B: begin
        if (cnt == per_c - CNT_W'(1)) begin
          cnt_nxt   = '0;
          wrap_c    = 1'b1;
          state_nxt = pending;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Per-channel phase is the shared count shifted by i*PHASE_STEP, folded into [0,P).
  always_comb begin
    logic [PH_W-1:0] ph;
    ph      = '0;
    pwm_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      ph = {1'b0, cnt} + PH_W'(i * PHASE_STEP);
      if (ph >= {1'b0, per_c}) ph = ph - {1'b0, per_c};
      pwm_nxt[i] = (state != IDLE) && (ph >= {1'b0, low_c});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= IDLE;
      cnt     <= '0;
      pwm     <= '0;
      tick    <= 1'b0;
      led0    <= 1'b0;
      led1    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
      pwm     <= pwm_nxt;
      tick    <= wrap_c;
      led0    <= (state == RUN_A);
      led1    <= (state == RUN_B);
    end
  end

endmodule
